// File: rtl/des_pkg.sv
`default_nettype none
// ============================================================================
// Module   : des_pkg
// Purpose  : Shared types and constants for the iterative DES sequencer.
//            Holds the controller state encoding, the round count and the
//            per-round C/D rotate schedule used for key derivation.
// Revision : 1.0 - initial release
// ============================================================================
package des_pkg;

    localparam int DES_ROUNDS = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_ROUND = 2'd2,
        ST_DONE  = 2'd3
    } des_ctrl_state_t;

    // Left-rotate amount applied to C/D before each encryption round.
    localparam logic [1:0] DES_KEY_SHIFTS [0:15] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

endpackage
`default_nettype wire

// File: rtl/des_key_shift_schedule.sv
`default_nettype none
// ============================================================================
// Module   : des_key_shift_schedule
// Purpose  : Combinational key-schedule lookup. Maps the current round and
//            mode to the C/D rotate amount and direction.
// Ports    : round_idx [3:0] in  - round number 0..15
//            decrypt         in  - 1 = decrypt (rotate right, reversed order)
//            shift     [1:0] out - rotate amount 0, 1 or 2
//            dir             out - 0 = left, 1 = right
// Revision : 1.0 - initial release
// ============================================================================
module des_key_shift_schedule
    import des_pkg::*;
(
    input  logic [3:0] round_idx,
    input  logic       decrypt,
    output logic [1:0] shift,
    output logic       dir
);

    // Decrypt walks the schedule backwards: round i uses entry 16-i, which
    // in 4-bit arithmetic is simply the two's complement of the index.
    logic [3:0] w_rev_idx;
    assign w_rev_idx = 4'd0 - round_idx;

    always_comb begin
        shift = DES_KEY_SHIFTS[round_idx];
        if (decrypt) begin
            // Decrypt round 0 starts from the un-rotated PC-1 key, which
            // already equals the last encryption subkey's C/D (total 28).
            shift = (round_idx == 4'd0) ? 2'd0 : DES_KEY_SHIFTS[w_rev_idx];
        end
    end

    assign dir = decrypt;

endmodule
`default_nettype wire

// File: rtl/des_round_controller.sv
`default_nettype none
// ============================================================================
// Module   : des_round_controller
// Purpose  : Sequencer for the iterative DES datapath. Accepts a block
//            request, pulses load, runs 16 rounds with key-rotate control,
//            then holds output-valid until the consumer takes the result.
// Ports    : clk_i, rst_i (sync, active-high)
//            start_i / ready_o        - request handshake
//            decrypt_i                - mode, sampled on acceptance
//            load_o                   - one-cycle IP / PC-1 latch strobe
//            round_en_o, round_idx_o  - round strobe and index
//            key_shift_o, key_dir_o   - C/D rotate amount / direction
//            last_round_o             - suppress L/R swap on final round
//            decrypt_o                - mode of the block in flight
//            out_valid_o / out_ready_i - result handshake
// Revision : 1.0 - initial release
// ============================================================================
module des_round_controller
    import des_pkg::*;
#(
    parameter int ROUNDS = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic       decrypt_i,
    output logic       ready_o,
    output logic       load_o,
    output logic       round_en_o,
    output logic [3:0] round_idx_o,
    output logic [1:0] key_shift_o,
    output logic       key_dir_o,
    output logic       last_round_o,
    output logic       decrypt_o,
    output logic       out_valid_o,
    input  logic       out_ready_i
);

    generate
        if (ROUNDS != DES_ROUNDS) begin : g_rounds_check
            $error("des_round_controller: only ROUNDS = 16 is supported");
        end
    endgenerate

    localparam logic [3:0] C_LAST_ROUND = 4'(ROUNDS - 1);

    des_ctrl_state_t r_state;
    logic [3:0]      r_cnt;
    logic            r_decrypt;
    logic            r_ready;
    logic            r_load;
    logic            r_round_en;
    logic            r_last;
    logic            r_out_valid;

    // Outputs are registered alongside the state so that each one reflects
    // the state being entered; the counter is kept at zero outside rounds.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 4'd0;
            r_decrypt   <= 1'b0;
            r_ready     <= 1'b1;
            r_load      <= 1'b0;
            r_round_en  <= 1'b0;
            r_last      <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        r_state   <= ST_LOAD;
                        r_decrypt <= decrypt_i;
                        r_ready   <= 1'b0;
                        r_load    <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    r_state    <= ST_ROUND;
                    r_cnt      <= 4'd0;
                    r_load     <= 1'b0;
                    r_round_en <= 1'b1;
                end
                ST_ROUND: begin
                    if (r_cnt == C_LAST_ROUND) begin
                        r_state     <= ST_DONE;
                        r_cnt       <= 4'd0;
                        r_round_en  <= 1'b0;
                        r_last      <= 1'b0;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_cnt  <= r_cnt + 4'd1;
                        r_last <= (r_cnt == C_LAST_ROUND - 4'd1);
                    end
                end
                ST_DONE: begin
                    if (out_ready_i) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                        r_ready     <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_cnt       <= 4'd0;
                    r_ready     <= 1'b1;
                    r_load      <= 1'b0;
                    r_round_en  <= 1'b0;
                    r_last      <= 1'b0;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    logic [1:0] w_shift;
    logic       w_dir;

    des_key_shift_schedule u_key_shift_schedule (
        .round_idx (r_cnt),
        .decrypt   (r_decrypt),
        .shift     (w_shift),
        .dir       (w_dir)
    );

    assign ready_o      = r_ready;
    assign load_o       = r_load;
    assign round_en_o   = r_round_en;
    assign round_idx_o  = r_cnt;
    assign key_shift_o  = r_round_en ? w_shift : 2'd0;
    assign key_dir_o    = r_round_en & w_dir;
    assign last_round_o = r_last;
    assign decrypt_o    = r_decrypt;
    assign out_valid_o  = r_out_valid;

endmodule
`default_nettype wire

// File: doc/des_round_controller.md
# des_round_controller

Sequencer for the iterative DES core. It accepts a block request over a valid/ready handshake and drives the shared datapath through load (IP and PC-1 latch), 16 one-cycle rounds and a final-permutation/output stage. Per round it supplies the key-schedule rotate amount and direction for encryption or decryption. The controller holds the result until the consumer takes it. It contains no data registers; L/R, C/D, the round function and the initial/inverse permutations live in the datapath.

## Interface
- `ROUNDS`, default 16: rounds per block; only 16 is supported, and the parameter exists for the counter width check.
- `clk_i`  in  1  single clock; all logic on the rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `start_i`  in  1  request valid; accepted when `start_i && ready_o`.
- `decrypt_i`  in  1  mode for the request; 1 = decrypt. Sampled only on acceptance.
- `ready_o`  out  1  controller idle, able to accept a request.
- `load_o`  out  1  one-cycle pulse: datapath latches IP(data) into L/R and PC-1(key) into C/D.
- `round_en_o`  out  1  datapath performs one round this cycle.
- `round_idx_o`  out  4  current round, 0..15; 0 when not in a round.
- `key_shift_o`  out  2  C/D rotate amount this round: 0, 1 or 2.
- `key_dir_o`  out  1  rotate direction: 0 = left (encrypt), 1 = right (decrypt).
- `last_round_o`  out  1  high with round 15: datapath suppresses the L/R swap.
- `decrypt_o`  out  1  latched mode of the block in flight.
- `out_valid_o`  out  1  datapath output (post-IP⁻¹) is valid.
- `out_ready_i`  in  1  consumer accepts; transfer when `out_valid_o && out_ready_i`.

## Operation
- FSM states: IDLE, LOAD, ROUND, DONE.
- **IDLE**
  - `ready_o` = 1.
  - On accept: latch `decrypt_i` into `decrypt_o`, go to LOAD.
- **LOAD**
  - `load_o` = 1 for exactly one cycle.
  - Clear the round counter, go to ROUND.
- **ROUND**
  - `round_en_o` = 1 and `round_idx_o` = counter; the counter increments every cycle.
  - At counter = 15, assert `last_round_o` and go to DONE.
- **DONE**
  - `out_valid_o` = 1, held stable until `out_ready_i`; then go to IDLE.
- **Key shift schedule**: S = {1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1}, index 0..15.
  - Encrypt: round i gets `key_shift_o` = S[i] and `key_dir_o` = 0.
  - Decrypt: round 0 gets shift 0; round i ≥ 1 gets S[16−i]; `key_dir_o` = 1.
  - The datapath rotates C/D by this amount before deriving the round subkey.
  - Sum check: encrypt totals 28 left; decrypt totals 27 right.
- **Outputs outside their states**: `key_shift_o`, `key_dir_o`, `round_en_o`, `last_round_o` and `load_o` are 0.
- **Boundary conditions**
  - `start_i` outside IDLE is ignored; no queueing.
  - `decrypt_i` changes after acceptance have no effect.
  - `out_ready_i` outside DONE is ignored.
  - `out_ready_i` held high before DONE gives a transfer on the first DONE cycle.
  - `rst_i` in any state: next state IDLE, counter 0, `decrypt_o` 0, all pulses dropped; the block in flight is lost.
  - `rst_i` has priority over a simultaneous `start_i`.

## Timing
- **Reset**
  - During the clock edge with `rst_i` = 1, all outputs go to 0 except `ready_o`.
  - `ready_o` is 1 from the cycle after the reset edge (IDLE).
- **Request accepted at cycle T**
  - T+1: `load_o`.
  - T+2..T+17: rounds 0..15.
  - T+17: `last_round_o`.
  - T+18: `out_valid_o`.
- **Latency**: 18 cycles from acceptance to `out_valid_o`.
- **Throughput**: minimum 19 cycles per block; `ready_o` returns the cycle after the output transfer.
- **Output decode**: all outputs are decoded from registered state/counter/mode only; there is no combinational path from inputs to outputs.

## Structure
- Package `des_pkg` holds:
  - state enum `des_ctrl_state_t`;
  - localparam `DES_ROUNDS` = 16;
  - shift schedule constant `DES_KEY_SHIFTS[0:15]`.
- One sub-module, `des_key_shift_schedule`: combinational (`round_idx`, `decrypt`) → (`shift`, `dir`), indexing `DES_KEY_SHIFTS`.
- The FSM and round counter stay in `des_round_controller`.

## Test plan
- **Encrypt sequence**: after reset, `start_i` = 1 and `decrypt_i` = 0 at T.
  - Expect `load_o` at T+1 and `round_idx_o` 0..15 at T+2..T+17.
  - Expect `key_shift_o` = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 and `key_dir_o` = 0.
  - Expect `last_round_o` only at T+17 and `out_valid_o` at T+18.
- **Decrypt sequence**: same stimulus with `decrypt_i` = 1.
  - Expect `key_shift_o` = 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 and `key_dir_o` = 1.
  - Expect `decrypt_o` = 1 from T+1.
- **Output backpressure**: `out_ready_i` = 0 for 5 cycles in DONE.
  - Expect `out_valid_o` held high for those 5 cycles with `ready_o` = 0.
  - When `out_ready_i` = 1, expect `ready_o` = 1 on the next cycle.
- **Busy start ignored**: pulse `start_i` with `decrypt_i` toggled at T+5 and T+10.
  - Expect no second `load_o` and `decrypt_o` unchanged.
- **Reset mid-round**: `rst_i` = 1 at round 7.
  - Next cycle: `ready_o` = 1, `round_en_o` = 0, `decrypt_o` = 0.
  - A new request then shows full 18-cycle latency from round 0.
- **Back-to-back blocks**: `out_ready_i` tied high, `start_i` tied high.
  - Expect `load_o` pulses exactly 19 cycles apart.
